// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and the occupancy-counter width helper for the UART buffer block
package uart_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int TX_DEPTH_DEF = 16;
  localparam int RX_DEPTH_DEF = 16;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO, pointers wrap at DEPTH-1 so any depth >= 2 works
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = TX_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop) rp <= inc(rp);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_buf_ctrl.sv
// uart_buf_ctrl: TX/RX word buffering between host and UART engines with sticky overflow and irq.
// Define UART_RX_OVERWRITE_EN to make an RX overflow drop the oldest word instead of the new one.
module uart_buf_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TX_DEPTH = TX_DEPTH_DEF,
  parameter int RX_DEPTH = RX_DEPTH_DEF,
  parameter int RX_THRESH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_ready,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         rd_ready,
  input  logic                         eng_rx_valid,
  input  logic [DATA_W-1:0]            eng_rx_data,
  output logic                         eng_tx_valid,
  output logic [DATA_W-1:0]            eng_tx_data,
  input  logic                         eng_tx_ready,
  output logic [cnt_w(TX_DEPTH)-1:0]   tx_count,
  output logic [cnt_w(RX_DEPTH)-1:0]   rx_count,
  output logic                         rx_ovf,
  input  logic                         ovf_clr,
  output logic                         irq
);
  localparam int CW_RX = cnt_w(RX_DEPTH);
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic rx_pop, rx_push, rx_pop_f, ovf_evt, ovf_nxt;
  logic [CW_RX-1:0] rx_cnt_nxt;
  assign wr_ready = !tx_full;
  assign eng_tx_valid = !tx_empty;
  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(wr_valid && wr_ready), .pop(eng_tx_valid && eng_tx_ready),
    .wdata(wr_data), .rdata(eng_tx_data), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );
  assign rd_valid = !rx_empty;
  assign rx_pop = rd_valid && rd_ready;
  assign ovf_evt = eng_rx_valid && rx_full && !rx_pop;
`ifdef UART_RX_OVERWRITE_EN
  assign rx_push = eng_rx_valid;
  assign rx_pop_f = rx_pop || ovf_evt;
`else
  assign rx_push = eng_rx_valid && !ovf_evt;
  assign rx_pop_f = rx_pop;
`endif
  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop_f),
    .wdata(eng_rx_data), .rdata(rd_data), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );
  // irq looks at next-state occupancy and flag so it lands on the same edge as the change
  assign rx_cnt_nxt = rx_count + CW_RX'(rx_push) - CW_RX'(rx_pop_f);
  assign ovf_nxt = ovf_evt || (rx_ovf && !ovf_clr);
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovf <= 1'b0;
      irq <= 1'b0;
    end else begin
      rx_ovf <= ovf_nxt;
      irq <= rx_cnt_nxt >= CW_RX'(RX_THRESH) || ovf_nxt;
    end
  end
endmodule
